// File: rtl/fpu_host_if.sv
// Handshake and data bundle between fpu_host, its byte source, its result sink and the FPU.
interface fpu_host_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] op_A_out;
  logic [31:0] op_B_out;
  logic [31:0] fpu_data_in;
  logic [3:0]  fpu_status_in;
  logic        fpu_flags_in;
  logic [7:0]  res_byte;
  logic        res_valid;
  logic        res_ready;
  logic        busy;

  modport master (
    output byte_in, byte_valid, fpu_data_in, fpu_status_in, fpu_flags_in, res_ready,
    input  byte_ready, op_A_out, op_B_out, res_byte, res_valid, busy
  );

  modport slave (
    input  byte_in, byte_valid, fpu_data_in, fpu_status_in, fpu_flags_in, res_ready,
    output byte_ready, op_A_out, op_B_out, res_byte, res_valid, busy
  );
endinterface

// File: rtl/fpu_host.sv
// Byte-serial front end for a multi-cycle FPU: loads operands A and B MSB-first,
// waits WAIT_CYCLES, captures the FPU result and streams it back as five bytes.
module fpu_host #(
  parameter int WAIT_CYCLES = 4
) (
  input logic       clock100KHz,
  input logic       reset,
  fpu_host_if.slave bus
);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, WAIT, CAPTURE, SEND} state_t;

  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_run;
  logic [2:0]  r_byteCnt;
  logic [7:0]  r_waitCnt;
  logic [31:0] r_shadowA;
  logic [31:0] r_shadowB;
  logic [31:0] r_opA;
  logic [31:0] r_opB;
  logic [31:0] r_data;
  logic [3:0]  r_status;
  logic        r_flag;
  logic        w_byteReady;
  logic        w_byteXfer;
  logic        w_resXfer;
  logic [7:0]  w_resByte;

  // r_run keeps byte_ready low while reset is held and for the edge on which it releases.
  assign w_byteReady = r_run && ((r_state == LOAD_A) || (r_state == LOAD_B));
  assign w_byteXfer  = w_byteReady && bus.byte_valid;
  assign w_resXfer   = (r_state == SEND) && bus.res_ready;

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD_A;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      LOAD_A:  if (w_byteXfer && (r_byteCnt == 3'd3)) w_nextState = LOAD_B;
      LOAD_B:  if (w_byteXfer && (r_byteCnt == 3'd3)) w_nextState = (WAIT_CYCLES == 1) ? CAPTURE : WAIT;
      WAIT:    if (r_waitCnt <= 8'd2) w_nextState = CAPTURE;
      CAPTURE: w_nextState = SEND;
      SEND:    if (w_resXfer && (r_byteCnt == 3'd4)) w_nextState = LOAD_A;
      default: w_nextState = LOAD_A;
    endcase
  end

  // One byte counter serves both loading and sending; it clears whenever the phase changes.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_run     <= 1'b0;
      r_byteCnt <= '0;
      r_waitCnt <= '0;
      r_shadowA <= '0;
      r_shadowB <= '0;
      r_opA     <= '0;
      r_opB     <= '0;
      r_data    <= '0;
      r_status  <= '0;
      r_flag    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_byteXfer || w_resXfer) begin
        r_byteCnt <= (w_nextState != r_state) ? 3'd0 : r_byteCnt + 3'd1;
      end
      if (w_byteXfer && (r_state == LOAD_A)) begin
        r_shadowA <= {r_shadowA[23:0], bus.byte_in};
      end
      if (w_byteXfer && (r_state == LOAD_B)) begin
        r_shadowB <= {r_shadowB[23:0], bus.byte_in};
        if (r_byteCnt == 3'd3) begin
          r_opA     <= r_shadowA;
          r_opB     <= {r_shadowB[23:0], bus.byte_in};
          r_waitCnt <= WAIT_LOAD;
        end
      end
      if (r_state == WAIT) begin
        r_waitCnt <= r_waitCnt - 8'd1;
      end
      if (r_state == CAPTURE) begin
        r_data   <= bus.fpu_data_in;
        r_status <= bus.fpu_status_in;
        r_flag   <= bus.fpu_flags_in;
      end
    end
  end

  always_comb begin
    w_resByte = '0;
    if (r_state == SEND) begin
      case (r_byteCnt)
        3'd0:    w_resByte = r_data[31:24];
        3'd1:    w_resByte = r_data[23:16];
        3'd2:    w_resByte = r_data[15:8];
        3'd3:    w_resByte = r_data[7:0];
        default: w_resByte = {3'b000, r_flag, r_status};
      endcase
    end
  end

  assign bus.byte_ready = w_byteReady;
  assign bus.op_A_out   = r_opA;
  assign bus.op_B_out   = r_opB;
  assign bus.res_byte   = w_resByte;
  assign bus.res_valid  = (r_state == SEND);
  assign bus.busy       = !((r_state == LOAD_A) && (r_byteCnt == 3'd0));

endmodule

// File: tb/tb_fpu_host.sv
// Self-checking bench for fpu_host: a transaction-level model predicts operands and
// result bytes, and one compare process checks the DUT against it every cycle.
`timescale 1ns/1ps
module tb_fpu_host;
  localparam int W = 4;

  logic clock100KHz = 1'b0;
  logic reset = 1'b1;
  fpu_host_if bus();

  fpu_host #(.WAIT_CYCLES(W)) dut (
    .clock100KHz(clock100KHz),
    .reset(reset),
    .bus(bus)
  );

  always #5000 clock100KHz = ~clock100KHz;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  always @(posedge clock100KHz) cycle <= cycle + 1;

  logic [31:0] mA = '0, mB = '0, pendA = '0, pendB = '0;
  logic [31:0] fpuResult = '0;
  logic [3:0]  fpuStatus = '0;
  logic        fpuFlag = 1'b0;
  logic [7:0]  q[$];
  logic [7:0]  rxBytes[5];
  bit          txActive = 0;
  bit          lastPop = 0;
  bit          expValid;
  int          opEdge = 0;
  int          rxCount = 0;
  int          sinceRelease = 0;
  int          stallIdx = -1;
  int          stallLeft = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The FPU answer is only correct in the window k=3..4 after the operand update.
  function automatic void fpuAt(input int k, output logic [31:0] d, output logic [3:0] s, output logic f);
    if (k >= 3 && k < 5) begin
      d = fpuResult; s = fpuStatus; f = fpuFlag;
    end else if (k >= 5) begin
      d = 32'h12345678; s = 4'h3; f = 1'b1;
    end else begin
      d = 32'hDEADBEEF; s = 4'h5; f = 1'b0;
    end
  endfunction

  function automatic void commitModel();
    logic [31:0] d;
    logic [3:0]  s;
    logic        f;
    opEdge = cycle;
    mA = pendA;
    mB = pendB;
    fpuAt(W, d, s, f);
    q.delete();
    q.push_back(d[31:24]);
    q.push_back(d[23:16]);
    q.push_back(d[15:8]);
    q.push_back(d[7:0]);
    q.push_back({3'b000, f, s});
    txActive = 1;
  endfunction

  initial begin
    bus.fpu_data_in   = 32'hDEADBEEF;
    bus.fpu_status_in = 4'h5;
    bus.fpu_flags_in  = 1'b0;
  end

  always @(negedge clock100KHz) begin
    logic [31:0] d;
    logic [3:0]  s;
    logic        f;
    fpuAt(txActive ? (cycle - opEdge) : -1, d, s, f);
    bus.fpu_data_in   = d;
    bus.fpu_status_in = s;
    bus.fpu_flags_in  = f;
  end

  always @(negedge clock100KHz) begin
    if (stallLeft > 0 && bus.res_valid && rxCount == stallIdx) begin
      bus.res_ready = 1'b0;
      stallLeft--;
    end else begin
      bus.res_ready = 1'b1;
    end
  end

  always @(negedge clock100KHz) begin
    #10;
    if (!reset) begin
      sinceRelease = 0;
      checkOutput("reset op_A", bus.op_A_out, 32'h0);
      checkOutput("reset op_B", bus.op_B_out, 32'h0);
      checkOutput("reset res_valid", 32'(bus.res_valid), 32'h0);
      checkOutput("reset res_byte", 32'(bus.res_byte), 32'h0);
      checkOutput("reset byte_ready", 32'(bus.byte_ready), 32'h0);
      checkOutput("reset busy", 32'(bus.busy), 32'h0);
    end else begin
      sinceRelease++;
      if (sinceRelease == 2) checkOutput("ready after reset", 32'(bus.byte_ready), 32'h1);
      if (lastPop) begin
        checkOutput("back-to-back ready", 32'(bus.byte_ready), 32'h1);
        checkOutput("idle busy", 32'(bus.busy), 32'h0);
        lastPop = 0;
      end
      checkOutput("op_A", bus.op_A_out, mA);
      checkOutput("op_B", bus.op_B_out, mB);
      expValid = txActive && ((cycle - opEdge) >= W) && (q.size() > 0);
      checkOutput("res_valid", 32'(bus.res_valid), 32'(expValid));
      if (bus.res_valid && q.size() > 0) begin
        checkOutput("res_byte", 32'(bus.res_byte), 32'(q[0]));
        if (bus.res_ready) begin
          if (rxCount < 5) rxBytes[rxCount] = bus.res_byte;
          rxCount++;
          void'(q.pop_front());
          if (q.size() == 0) begin
            txActive = 0;
            lastPop = 1;
          end
        end
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input bit gap, input bit isLast);
    int guard = 0;
    @(negedge clock100KHz);
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && guard < 50) begin
      @(negedge clock100KHz);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL byte_ready timeout: got 0 expected 1");
    end
    @(posedge clock100KHz);
    #1;
    if (isLast) commitModel();
    bus.byte_valid = 1'b0;
    if (gap) @(negedge clock100KHz);
  endtask

  task automatic applyReset(input int n);
    @(negedge clock100KHz);
    reset = 1'b0;
    bus.byte_valid = 1'b0;
    q.delete();
    mA = '0;
    mB = '0;
    txActive = 0;
    lastPop = 0;
    repeat (n) @(negedge clock100KHz);
    reset = 1'b1;
  endtask

  task automatic runTransaction(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                                input logic [3:0] st, input logic fl, input bit gap);
    logic [63:0] ops;
    int guard = 0;
    ops = {a, b};
    pendA = a;
    pendB = b;
    fpuResult = res;
    fpuStatus = st;
    fpuFlag = fl;
    rxCount = 0;
    for (int i = 0; i < 8; i++) sendByte(ops[63 - 8*i -: 8], gap, i == 7);
    while (txActive && guard < 200) begin
      @(posedge clock100KHz);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL result timeout: got %0d bytes expected 5", rxCount);
    end
  endtask

  task automatic checkBytes(input string name, input logic [39:0] e);
    checkOutput({name, " count"}, 32'(rxCount), 32'd5);
    for (int i = 0; i < 5; i++) checkOutput(name, 32'(rxBytes[i]), 32'(e[39 - 8*i -: 8]));
  endtask

  task automatic applyStimulus();
    #100;
    reset = 1'b0;
    repeat (3) @(negedge clock100KHz);
    reset = 1'b1;

    runTransaction(32'h3F800000, 32'h40000000, 32'h40400000, 4'b0001, 1'b0, 0);
    checkOutput("basic op_A", bus.op_A_out, 32'h3F800000);
    checkOutput("basic op_B", bus.op_B_out, 32'h40000000);
    checkBytes("basic res", 40'h4040000001);

    stallIdx = 2;
    stallLeft = 10;
    runTransaction(32'h3F800000, 32'h40000000, 32'hC0A00000, 4'b0010, 1'b0, 0);
    checkOutput("stall consumed", 32'(stallLeft), 32'd0);
    checkBytes("backpressure res", 40'hC0A0000002);
    stallIdx = -1;

    runTransaction(32'h3F800000, 32'h40000000, 32'h40400000, 4'b0001, 1'b0, 1);
    checkOutput("gap op_A", bus.op_A_out, 32'h3F800000);
    checkOutput("gap op_B", bus.op_B_out, 32'h40000000);
    checkBytes("gap res", 40'h4040000001);

    runTransaction(32'h41200000, 32'hC1200000, 32'h00000000, 4'b1010, 1'b1, 0);
    checkBytes("flag res", 40'h000000001A);

    sendByte(8'h11, 0, 0);
    sendByte(8'h22, 0, 0);
    sendByte(8'h33, 0, 0);
    sendByte(8'h44, 0, 0);
    sendByte(8'h55, 0, 0);
    applyReset(3);
    runTransaction(32'hAABBCCDD, 32'h01020304, 32'h7F800000, 4'b0100, 1'b0, 0);
    checkOutput("post-reset op_A", bus.op_A_out, 32'hAABBCCDD);
    checkOutput("post-reset op_B", bus.op_B_out, 32'h01020304);
    checkBytes("post-reset res", 40'h7F80000004);

    repeat (3) @(negedge clock100KHz);
  endtask

  initial begin
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    bus.res_ready = 1'b1;
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(5000 * 10000);
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/fpu_host.md
FPU_HOST -- requirements
Module: fpu_host

Interface
REQ-001 Parameter: WAIT_CYCLES, default 4, clock cycles from operand presentation to result sampling; legal range 1..255.
REQ-002 clock100KHz  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; asserting (0) clears all state immediately; release is synchronous to clock100KHz.
REQ-004 byte_in  in  8  operand byte stream.
REQ-005 byte_valid  in  1  byte_in holds a valid byte.
REQ-006 byte_ready  out  1  block accepts a byte this cycle.
REQ-007 op_A_out  out  32  operand A driven to the FPU.
REQ-008 op_B_out  out  32  operand B driven to the FPU.
REQ-009 fpu_data_in  in  32  FPU result (the FPU's data_out).
REQ-010 fpu_status_in  in  4  FPU status (the FPU's status_out).
REQ-011 fpu_flags_in  in  1  FPU flag (the FPU's flags_out).
REQ-012 res_byte  out  8  result byte stream.
REQ-013 res_valid  out  1  res_byte holds a valid byte.
REQ-014 res_ready  in  1  consumer accepts res_byte this cycle.
REQ-015 busy  out  1  high in any state other than LOAD_A with zero bytes received.

Function
REQ-016 FSM states SHALL be LOAD_A, LOAD_B, WAIT, CAPTURE and SEND.
REQ-017 Byte transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 exactly in LOAD_A and LOAD_B.
REQ-018 LOAD_A SHALL assemble 4 bytes MSB-first into an A shadow register, then go to LOAD_B; LOAD_B SHALL do the same into a B shadow register.
REQ-019 On the 4th accepted LOAD_B byte, the next edge SHALL copy both shadows to op_A_out/op_B_out, load the wait counter with WAIT_CYCLES and enter WAIT.
REQ-020 op_A_out and op_B_out SHALL change only on that edge and hold otherwise.
REQ-021 Gaps in byte_valid SHALL stall loading with no loss or duplication of bytes.
REQ-022 WAIT SHALL decrement the counter each cycle and enter CAPTURE when the counter reaches 1. Sampling therefore occurs WAIT_CYCLES cycles after the op_*_out update.
REQ-023 CAPTURE SHALL last one cycle, latching fpu_data_in, fpu_status_in and fpu_flags_in, then enter SEND.
REQ-024 SEND SHALL emit 5 bytes in this order: data[31:24], data[23:16], data[15:8], data[7:0], then {3'b000, flags, status[3:0]}.
REQ-025 res_valid SHALL be 1 throughout SEND, and res_byte SHALL stay stable until res_valid=1 and res_ready=1 in the same cycle.
REQ-026 SEND SHALL advance one byte per handshake; the 5th handshake SHALL return the FSM to LOAD_A with the byte counters cleared.
REQ-027 res_ready=0 SHALL hold SEND indefinitely; byte_in SHALL be ignored outside LOAD_A/LOAD_B.
REQ-028 The block SHALL support back-to-back transactions: LOAD_A is accepting bytes in the cycle after the final SEND handshake.

Reset
REQ-029 While reset=0, the following SHALL hold: state=LOAD_A, byte and wait counters=0, shadows=0, op_A_out=0, op_B_out=0, captured registers=0, res_byte=0, res_valid=0, byte_ready=0, busy=0.
REQ-030 byte_ready SHALL rise in the first cycle after reset is released.
REQ-031 Reset asserted in any state, including mid-load and mid-SEND, SHALL abort the transaction; the partial transaction SHALL NOT resume or be replayed.

Verification
REQ-032 Basic add: bytes 3F 80 00 00 40 00 00 00, FPU model returns 0x40400000, status 4'b0001, flag 0 -> op_A_out=0x3F800000, op_B_out=0x40000000; res bytes 40 40 00 00 01.
REQ-033 Latency: WAIT_CYCLES=4; the FPU model changes fpu_data_in 3 cycles after op update and again at 5 cycles -> the value present at cycle 4 is captured.
REQ-034 Backpressure: res_ready low for 10 cycles at byte 2 -> res_valid held, res_byte stable at byte 2, no byte skipped.
REQ-035 Input gaps: byte_valid toggled 1,0,1,0 across all 8 bytes -> same operands as the gap-free case.
REQ-036 Reset mid-load: reset pulsed low after 5 bytes, then a full transaction -> outputs 0 during reset; the new operands are loaded correctly; no stale bytes.
REQ-037 Flag packing: status 4'b1010, flag 1 -> 5th res byte = 0x1A.
